seg_scan_ndig: RTL and testbench

Parametrised time-multiplexed 7-segment driver for NUM_DIG hex digits. It is the multi-digit successor to the two-digit hex display. It adds:
- a programmable refresh prescaler
- anti-ghost blanking
- leading-zero suppression
- per-digit decimal points and enables
- selectable output polarity
- tear-free frame-synchronous data update

It sits between the frame controller's status registers and the board display pins.

---
 rtl/seg_scan_ndig_if.sv | 24 ++
 rtl/seg_scan_ndig.sv | 161 ++++++++++++++++
 tb/tb_seg_scan_ndig.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ndig_if.sv
// Display-side bundle for seg_scan_ndig: load/control inputs plus frame pulse and pin outputs.
// The master drives data and control; the slave is the scanner itself.
interface seg_scan_ndig_if #(
  parameter int NUM_DIG = 6
);
  logic [4*NUM_DIG-1:0] i_data;
  logic [NUM_DIG-1:0]   i_dp;
  logic [NUM_DIG-1:0]   i_en;
  logic                 i_lzb;
  logic                 i_load;
  logic                 o_frame;
  logic [7:0]           SEG;
  logic [NUM_DIG-1:0]   DIG;

  modport master (
    output i_data, i_dp, i_en, i_lzb, i_load,
    input  o_frame, SEG, DIG
  );

  modport slave (
    input  i_data, i_dp, i_en, i_lzb, i_load,
    output o_frame, SEG, DIG
  );
endinterface

// File: rtl/seg_scan_ndig.sv
// Time-multiplexed N-digit hex 7-segment scanner with anti-ghost blanking,
// leading-zero suppression, per-digit enables and frame-synchronous data update.
module seg_scan_ndig #(
  parameter int NUM_DIG     = 6,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16,
  parameter int SEG_ACT_LOW = 0,
  parameter int DIG_ACT_LOW = 0
) (
  input logic         i_clk,
  input logic         i_rst_n,
  seg_scan_ndig_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIG);
  localparam int DW = 4 * NUM_DIG;
  localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIG - 1);
  localparam logic [7:0] SEG_MASK = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIG-1:0] DIG_MASK = (DIG_ACT_LOW != 0) ? {NUM_DIG{1'b1}} : {NUM_DIG{1'b0}};

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [PW-1:0]      pcnt_r;
  logic [IW-1:0]      idx_r;
  logic [DW-1:0]      pend_data_r;
  logic [NUM_DIG-1:0] pend_dp_r;
  logic               pend_valid_r;
  logic [DW-1:0]      act_data_r;
  logic [NUM_DIG-1:0] act_dp_r;
  logic               frame_r;
  logic [7:0]         seg_r;
  logic [NUM_DIG-1:0] dig_r;

  logic               slot_end_s;
  logic               wrap_s;
  logic [3:0]         nib_s [NUM_DIG];
  logic [NUM_DIG-1:0] lz_s;
  logic               blank_s;
  logic [7:0]         seg_nxt_s;
  logic [NUM_DIG-1:0] dig_nxt_s;

  assign slot_end_s = (pcnt_r == PCNT_MAX);
  assign wrap_s     = slot_end_s && (idx_r == IDX_MAX);

  // Slot prescaler, digit index and frame pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pcnt_r  <= '0;
      idx_r   <= '0;
      frame_r <= 1'b0;
    end else begin
      frame_r <= wrap_s;
      if (slot_end_s) begin
        pcnt_r <= '0;
        idx_r  <= (idx_r == IDX_MAX) ? IW'(0) : idx_r + IW'(1);
      end else begin
        pcnt_r <= pcnt_r + PW'(1);
      end
    end
  end

  // Pending capture and tear-free promotion to the displayed copy at frame wrap
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_data_r  <= '0;
      pend_dp_r    <= '0;
      pend_valid_r <= 1'b0;
      act_data_r   <= '0;
      act_dp_r     <= '0;
    end else begin
      if (bus.i_load) begin
        pend_data_r <= bus.i_data;
        pend_dp_r   <= bus.i_dp;
      end
      if (wrap_s) begin
        pend_valid_r <= 1'b0;
        if (bus.i_load) begin
          act_data_r <= bus.i_data;
          act_dp_r   <= bus.i_dp;
        end else if (pend_valid_r) begin
          act_data_r <= pend_data_r;
          act_dp_r   <= pend_dp_r;
        end
      end else if (bus.i_load) begin
        pend_valid_r <= 1'b1;
      end
    end
  end

  // lz_s[k]: nibbles k..top are all zero, scanned from the most significant digit down
  always_comb begin
    logic run;
    run  = 1'b1;
    lz_s = '0;
    for (int k = NUM_DIG - 1; k >= 0; k--) begin
      nib_s[k] = act_data_r[4*k +: 4];
      run      = run & (nib_s[k] == 4'h0);
      lz_s[k]  = run;
    end
  end

  // Logical segment/digit selection for the current slot position
  always_comb begin
    seg_nxt_s = 8'h00;
    dig_nxt_s = '0;
    blank_s   = bus.i_lzb && (idx_r != IW'(0)) && lz_s[idx_r];
    if (int'(pcnt_r) < BLANK_CYC) begin
      seg_nxt_s = 8'h00;
      dig_nxt_s = '0;
    end else if (!bus.i_en[idx_r]) begin
      seg_nxt_s = 8'h00;
      dig_nxt_s = '0;
    end else begin
      dig_nxt_s    = {{(NUM_DIG-1){1'b0}}, 1'b1} << idx_r;
      seg_nxt_s[7] = act_dp_r[idx_r];
      if (blank_s) begin
        seg_nxt_s[6:0] = 7'h00;
      end else begin
        seg_nxt_s[6:0] = hex_to_seg(nib_s[idx_r]);
      end
    end
  end

  // Pin registers carry the polarity-adjusted value so reset lands on the inactive level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seg_r <= SEG_MASK;
      dig_r <= DIG_MASK;
    end else begin
      seg_r <= seg_nxt_s ^ SEG_MASK;
      dig_r <= dig_nxt_s ^ DIG_MASK;
    end
  end

  assign bus.SEG     = seg_r;
  assign bus.DIG     = dig_r;
  assign bus.o_frame = frame_r;
endmodule

// File: tb/tb_seg_scan_ndig.sv
// Bench for seg_scan_ndig: NUM_DIG=4, REFRESH_DIV=4, BLANK_CYC=1, one active-high and one
// active-low instance driven identically; frame expectations are queued then compared per cycle.
module tb_seg_scan_ndig;
  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        lzb;
    logic [31:0] segs;
  } vec_t;

  typedef struct {
    logic [7:0] seg;
    logic [3:0] dig;
    logic       frame;
  } exp_t;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;
  exp_t sbq[$];
  vec_t vt[8];
  vec_t prev;

  always #5 i_clk = ~i_clk;

  seg_scan_ndig_if #(.NUM_DIG(4)) b1 ();
  seg_scan_ndig_if #(.NUM_DIG(4)) b2 ();

  seg_scan_ndig #(.NUM_DIG(4), .REFRESH_DIV(4), .BLANK_CYC(1), .SEG_ACT_LOW(0), .DIG_ACT_LOW(0))
    dut_hi (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b1));
  seg_scan_ndig #(.NUM_DIG(4), .REFRESH_DIV(4), .BLANK_CYC(1), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1))
    dut_lo (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_ctrl(input logic [3:0] en, input logic lzb);
    b1.i_en = en;  b2.i_en = en;
    b1.i_lzb = lzb; b2.i_lzb = lzb;
  endtask

  task automatic set_load(input logic ld, input logic [15:0] d, input logic [3:0] dp);
    b1.i_load = ld; b2.i_load = ld;
    b1.i_data = d;  b2.i_data = d;
    b1.i_dp = dp;   b2.i_dp = dp;
  endtask

  task automatic check_pins(input string name, input logic [7:0] seg, input logic [3:0] dig);
    chk({name, " seg"}, {24'h0, b1.SEG}, {24'h0, seg});
    chk({name, " dig"}, {28'h0, b1.DIG}, {28'h0, dig});
    chk({name, " seg_n"}, {24'h0, b2.SEG}, {24'h0, ~seg});
    chk({name, " dig_n"}, {28'h0, b2.DIG}, {28'h0, ~dig});
  endtask

  task automatic wait_frame();
    int n = 0;
    while (b1.o_frame !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("frame_wait", {31'h0, b1.o_frame}, 32'h1);
  endtask

  // Starts on an o_frame sample; ends on the next one. Optional loads at slot-cycle la / lb.
  task automatic run_frame(input logic [3:0] en, input logic lzb, input logic [31:0] segs,
                           input int la, input logic [15:0] da, input logic [3:0] pa,
                           input int lb, input logic [15:0] db, input logic [3:0] pb);
    set_ctrl(en, lzb);
    for (int s = 1; s <= 16; s++) begin
      exp_t e;
      int slot;
      int pos;
      slot = (s - 1) / 4;
      pos  = (s - 1) % 4;
      e.frame = (s == 16);
      if (pos == 0 || !en[slot]) begin
        e.seg = 8'h00;
        e.dig = 4'h0;
      end else begin
        e.seg = segs[slot*8 +: 8];
        e.dig = 4'b0001 << slot;
      end
      sbq.push_back(e);
    end
    for (int s = 1; s <= 16; s++) begin
      exp_t e;
      if (s == la) set_load(1'b1, da, pa);
      else if (s == lb) set_load(1'b1, db, pb);
      else begin
        b1.i_load = 1'b0;
        b2.i_load = 1'b0;
      end
      tick();
      e = sbq.pop_front();
      check_pins($sformatf("frame s%0d", s), e.seg, e.dig);
      chk($sformatf("o_frame s%0d", s), {31'h0, b1.o_frame}, {31'h0, e.frame});
      chk($sformatf("o_frame_n s%0d", s), {31'h0, b2.o_frame}, {31'h0, e.frame});
    end
    b1.i_load = 1'b0;
    b2.i_load = 1'b0;
  endtask

  initial begin
    vt[0] = '{16'h12AF, 4'h0, 4'hF, 1'b0, 32'h065B7771};
    vt[1] = '{16'h0050, 4'h0, 4'hF, 1'b1, 32'h00006D3F};
    vt[2] = '{16'h0050, 4'h8, 4'hF, 1'b1, 32'h80006D3F};
    vt[3] = '{16'h0000, 4'h0, 4'hF, 1'b1, 32'h0000003F};
    vt[4] = '{16'h3456, 4'h5, 4'hB, 1'b0, 32'h4F006DFD};
    vt[5] = '{16'hBCDE, 4'hF, 4'hF, 1'b1, 32'hFCB9DEF9};
    vt[6] = '{16'h0800, 4'h0, 4'hF, 1'b1, 32'h007F3F3F};
    vt[7] = '{16'h9008, 4'h0, 4'hF, 1'b0, 32'h6F3F3F7F};

    set_ctrl(4'hF, 1'b0);
    set_load(1'b0, 16'h0000, 4'h0);

    // reset state with clock running, then first active digit after release
    tick();
    tick();
    check_pins("reset", 8'h00, 4'h0);
    chk("reset o_frame", {31'h0, b1.o_frame}, 32'h0);
    #3 i_rst_n = 1'b1;
    tick();
    check_pins("post_reset blank", 8'h00, 4'h0);
    tick();
    check_pins("post_reset dig0", 8'h3F, 4'h1);
    wait_frame();

    prev = '{16'h0000, 4'h0, 4'hF, 1'b0, 32'h3F3F3F3F};
    for (int i = 0; i < 8; i++) begin
      run_frame(prev.en, prev.lzb, prev.segs, 4, vt[i].data, vt[i].dp, 0, 16'h0, 4'h0);
      run_frame(vt[i].en, vt[i].lzb, vt[i].segs, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
      prev = vt[i];
    end

    // two loads in one frame: old frame intact, last load wins next frame
    run_frame(4'hF, 1'b0, 32'h6F3F3F7F, 3, 16'h1111, 4'h0, 8, 16'h2222, 4'h0);
    // load on the wrap cycle itself shows up in the frame that starts there
    run_frame(4'hF, 1'b0, 32'h5B5B5B5B, 16, 16'h4321, 4'h0, 0, 16'h0, 4'h0);
    run_frame(4'hF, 1'b0, 32'h664F5B06, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

    // asynchronous reset mid-slot
    tick();
    tick();
    check_pins("pre_async", 8'h06, 4'h1);
    #2 i_rst_n = 1'b0;
    #1;
    check_pins("async_reset", 8'h00, 4'h0);
    chk("async o_frame", {31'h0, b1.o_frame}, 32'h0);
    tick();
    check_pins("held_reset", 8'h00, 4'h0);
    #3 i_rst_n = 1'b1;
    tick();
    check_pins("restart blank", 8'h00, 4'h0);
    tick();
    check_pins("restart dig0", 8'h3F, 4'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
